// File: rtl/fpu_sink_pkg.sv
// Shared definitions for the FPU result sink: flag layout, the stored entry
// format and the saturating counter increment.
package fpu_sink_pkg;

  localparam int FLAG_W = 3;

  // Bit positions inside the stored flag field, {INF, NaN, OVFL}.
  localparam int FLG_OVFL = 0;
  localparam int FLG_NAN  = 1;
  localparam int FLG_INF  = 2;

  // Default result word width used by the packed entry layout.
  localparam int DEF_DATA_W = 32;

  typedef logic [FLAG_W-1:0] flags_t;

  // One FIFO entry: flags in the upper bits, result word in the lower bits.
  typedef struct packed {
    flags_t                flags;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

  // Saturating increment: holds at max_v, otherwise adds one.
  // Counters up to 32 bits wide are supported.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] max_v);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fpu_sink_fifo.sv
// Generic first-word-fall-through FIFO. The head entry is shown on rd_data
// whenever the FIFO is non-empty; a write becomes visible one cycle after it
// is accepted (no bypass). A write is accepted while not full, or while full
// if the head is popped in the same cycle.
// Handshake: a transfer on the read side happens on a rising clk edge where
// rd_valid & rd_ready are both 1; rd_data is held while rd_valid & ~rd_ready.
module fpu_sink_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       push
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          pop;

  assign full     = (cnt == LW'(DEPTH));
  assign empty    = (cnt == '0);
  assign rd_valid = ~empty;
  assign pop      = rd_valid & rd_ready;
  assign push     = wr_valid & (~full | pop);
  assign level    = cnt;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap modulo DEPTH; occupancy follows push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fpu_result_sink.sv
// Consumer end of the FPU result interface. Every DO_VALID beat is queued
// with its flags; beats arriving while the queue is full (and not being
// popped) are dropped, flagged by sticky OVERRUN and counted.
// Build option: define FPU_RESULT_SINK_STATS_EN to build the saturating
// DROP/OVFL/NAN/INF counters; without it those outputs are tied to 0 and
// CLR_STAT clears only OVERRUN.
module fpu_result_sink
  import fpu_sink_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     DO_VALID,
  input  logic [DATA_W-1:0]        RESULT,
  input  logic                     OVFL,
  input  logic                     NaN,
  input  logic                     INF,
  input  logic                     RD_READY,
  output logic                     RD_VALID,
  output logic [DATA_W-1:0]        RD_DATA,
  output logic [FLAG_W-1:0]        RD_FLAGS,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     OVERRUN,
  input  logic                     CLR_STAT,
  output logic [CNT_W-1:0]         DROP_CNT,
  output logic [CNT_W-1:0]         OVFL_CNT,
  output logic [CNT_W-1:0]         NAN_CNT,
  output logic [CNT_W-1:0]         INF_CNT
);

  localparam int EW = FLAG_W + DATA_W;

  flags_t          beat_flags;
  logic [EW-1:0]   rd_entry;
  logic            push;
  logic            drop;

  // Assemble the flag field in {INF, NaN, OVFL} order.
  always_comb begin
    beat_flags           = '0;
    beat_flags[FLG_OVFL] = OVFL;
    beat_flags[FLG_NAN]  = NaN;
    beat_flags[FLG_INF]  = INF;
  end

  fpu_sink_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (RST),
    .wr_valid (DO_VALID),
    .wr_data  ({beat_flags, RESULT}),
    .rd_ready (RD_READY),
    .rd_valid (RD_VALID),
    .rd_data  (rd_entry),
    .level    (LEVEL),
    .full     (FULL),
    .empty    (EMPTY),
    .push     (push)
  );

  assign RD_DATA  = rd_entry[DATA_W-1:0];
  assign RD_FLAGS = rd_entry[DATA_W +: FLAG_W];
  assign drop     = DO_VALID & ~push;

  // Sticky overrun; clear has priority over a same-cycle drop.
  always_ff @(posedge clk or posedge RST) begin
    if (RST)           OVERRUN <= 1'b0;
    else if (CLR_STAT) OVERRUN <= 1'b0;
    else if (drop)     OVERRUN <= 1'b1;
  end

`ifdef FPU_RESULT_SINK_STATS_EN
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] drop_q, ovfl_q, nan_q, inf_q;

  // Saturating statistics; clear wins over any same-cycle increment.
  always_ff @(posedge clk or posedge RST) begin
    if (RST || CLR_STAT) begin
      drop_q <= '0;
      ovfl_q <= '0;
      nan_q  <= '0;
      inf_q  <= '0;
    end else begin
      if (drop)            drop_q <= CNT_W'(sat_inc(32'(drop_q), CNT_MAX));
      if (DO_VALID && OVFL) ovfl_q <= CNT_W'(sat_inc(32'(ovfl_q), CNT_MAX));
      if (DO_VALID && NaN)  nan_q  <= CNT_W'(sat_inc(32'(nan_q),  CNT_MAX));
      if (DO_VALID && INF)  inf_q  <= CNT_W'(sat_inc(32'(inf_q),  CNT_MAX));
    end
  end

  assign DROP_CNT = drop_q;
  assign OVFL_CNT = ovfl_q;
  assign NAN_CNT  = nan_q;
  assign INF_CNT  = inf_q;
`else
  assign DROP_CNT = '0;
  assign OVFL_CNT = '0;
  assign NAN_CNT  = '0;
  assign INF_CNT  = '0;
`endif

endmodule

// File: tb/tb_fpu_result_sink.sv
// Directed bench for fpu_result_sink (DEPTH=8, CNT_W=4 so saturation is
// reachable). Counter expectations are zero when the statistics build
// option is not defined.
module tb_fpu_result_sink;
  import fpu_sink_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;
`ifdef FPU_RESULT_SINK_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              do_valid;
  logic [DATA_W-1:0] result;
  logic              ovfl, nan, inf;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [FLAG_W-1:0] rd_flags;
  logic [LW-1:0]     level;
  logic              full, empty, overrun;
  logic              clr_stat;
  logic [CNT_W-1:0]  drop_cnt, ovfl_cnt, nan_cnt, inf_cnt;

  int checks = 0;
  int errors = 0;

  fpu_result_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .RST      (rst),
    .DO_VALID (do_valid),
    .RESULT   (result),
    .OVFL     (ovfl),
    .NaN      (nan),
    .INF      (inf),
    .RD_READY (rd_ready),
    .RD_VALID (rd_valid),
    .RD_DATA  (rd_data),
    .RD_FLAGS (rd_flags),
    .LEVEL    (level),
    .FULL     (full),
    .EMPTY    (empty),
    .OVERRUN  (overrun),
    .CLR_STAT (clr_stat),
    .DROP_CNT (drop_cnt),
    .OVFL_CNT (ovfl_cnt),
    .NAN_CNT  (nan_cnt),
    .INF_CNT  (inf_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DATA_W-1:0] d, input logic [2:0] f);
    do_valid = 1'b1;
    result   = d;
    {inf, nan, ovfl} = f;
  endtask

  task automatic idle();
    do_valid = 1'b0;
    result   = '0;
    {inf, nan, ovfl} = 3'b000;
  endtask

  task automatic clear_stats();
    clr_stat = 1'b1;
    step();
    clr_stat = 1'b0;
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) step();
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [CNT_W-1:0] e;
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(DATA_W'(i + 1), 3'b111);
      step();
    end
    idle();
    e = CNT_W'(3 * STATS);
    checks++; if (ovfl_cnt !== e) begin $display("FAIL pre_reset_ovfl: got %0d exp %0d", ovfl_cnt, e); errors++; end
    checks++; if (level !== LW'(3)) begin $display("FAIL pre_reset_level: got %0d exp 3", level); errors++; end
    #2 rst = 1'b1;
    #1;
    checks++; if (rd_valid !== 1'b0) begin $display("FAIL rst_rd_valid: got %b exp 0", rd_valid); errors++; end
    checks++; if (level !== '0) begin $display("FAIL rst_level: got %0d exp 0", level); errors++; end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin $display("FAIL rst_empty_full: got %b%b exp 10", empty, full); errors++; end
    checks++; if (rd_data !== '0 || rd_flags !== '0) begin $display("FAIL rst_rd_data: got %0h/%0b exp 0/0", rd_data, rd_flags); errors++; end
    checks++; if ({drop_cnt, ovfl_cnt, nan_cnt, inf_cnt} !== '0 || overrun !== 1'b0) begin
      $display("FAIL rst_stats: got %0d %0d %0d %0d ov=%b exp 0", drop_cnt, ovfl_cnt, nan_cnt, inf_cnt, overrun); errors++; end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_in_order();
    logic [DATA_W-1:0] vals [5];
    vals = '{32'h3F8, 32'h0, 32'hBF8, 32'hCCCCD, 32'h89680};
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      beat(vals[i], 3'b000);
      if (i == 0) begin
        #1;
        checks++; if (rd_valid !== 1'b0) begin $display("FAIL no_bypass: got %b exp 0", rd_valid); errors++; end
      end
      step();
      checks++; if (rd_valid !== 1'b1 || rd_data !== vals[i]) begin
        $display("FAIL in_order_%0d: got v=%b %0h exp v=1 %0h", i, rd_valid, rd_data, vals[i]); errors++; end
    end
    idle();
    step();
    rd_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin $display("FAIL in_order_empty: got %b exp 1", empty); errors++; end
  endtask

  task automatic test_overflow();
    clear_stats();
    rd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      beat(DATA_W'(100 + i), 3'b000);
      step();
    end
    idle();
    checks++; if (level !== LW'(8) || full !== 1'b1) begin $display("FAIL ovf_level: got %0d f=%b exp 8 f=1", level, full); errors++; end
    checks++; if (drop_cnt !== CNT_W'(2 * STATS)) begin $display("FAIL ovf_drop_cnt: got %0d exp %0d", drop_cnt, 2 * STATS); errors++; end
    checks++; if (overrun !== 1'b1) begin $display("FAIL ovf_overrun: got %b exp 1", overrun); errors++; end
    // Head must hold while not ready.
    step();
    checks++; if (rd_data !== DATA_W'(100)) begin $display("FAIL ovf_hold: got %0d exp 100", rd_data); errors++; end
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (rd_data !== DATA_W'(100 + i)) begin $display("FAIL ovf_drain_%0d: got %0d exp %0d", i, rd_data, 100 + i); errors++; end
      step();
    end
    rd_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin $display("FAIL ovf_drain_empty: got %b exp 1", empty); errors++; end
  endtask

  task automatic test_full_push_pop();
    clear_stats();
    checks++; if (overrun !== 1'b0) begin $display("FAIL clr_overrun: got %b exp 0", overrun); errors++; end
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(DATA_W'(200 + i), 3'b000);
      step();
    end
    beat(DATA_W'(208), 3'b000);
    rd_ready = 1'b1;
    step();
    idle();
    rd_ready = 1'b0;
    checks++; if (level !== LW'(8) || full !== 1'b1) begin $display("FAIL fpp_level: got %0d exp 8", level); errors++; end
    checks++; if (overrun !== 1'b0 || drop_cnt !== '0) begin $display("FAIL fpp_no_drop: got ov=%b d=%0d exp 0 0", overrun, drop_cnt); errors++; end
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (rd_data !== DATA_W'(201 + i)) begin $display("FAIL fpp_drain_%0d: got %0d exp %0d", i, rd_data, 201 + i); errors++; end
      step();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_flags();
    logic [2:0] fl [4];
    fl = '{3'b001, 3'b110, 3'b111, 3'b000};
    clear_stats();
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(DATA_W'(32'hF000 + i), fl[i]);
      step();
    end
    idle();
    checks++; if (ovfl_cnt !== CNT_W'(2 * STATS)) begin $display("FAIL flg_ovfl_cnt: got %0d exp %0d", ovfl_cnt, 2 * STATS); errors++; end
    checks++; if (nan_cnt !== CNT_W'(2 * STATS)) begin $display("FAIL flg_nan_cnt: got %0d exp %0d", nan_cnt, 2 * STATS); errors++; end
    checks++; if (inf_cnt !== CNT_W'(2 * STATS)) begin $display("FAIL flg_inf_cnt: got %0d exp %0d", inf_cnt, 2 * STATS); errors++; end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_flags !== fl[i] || rd_data !== DATA_W'(32'hF000 + i)) begin
        $display("FAIL flg_entry_%0d: got %b %0h exp %b %0h", i, rd_flags, rd_data, fl[i], 32'hF000 + i); errors++; end
      step();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_saturation_clear();
    clear_stats();
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      beat(DATA_W'(i), 3'b001);
      step();
    end
    checks++; if (ovfl_cnt !== CNT_W'(15 * STATS)) begin $display("FAIL sat_ovfl: got %0d exp %0d", ovfl_cnt, 15 * STATS); errors++; end
    // Clear with a same-cycle OVFL beat: clear wins, beat still queued.
    rd_ready = 1'b0;
    clr_stat = 1'b1;
    beat(DATA_W'(20), 3'b001);
    step();
    clr_stat = 1'b0;
    idle();
    checks++; if (ovfl_cnt !== '0) begin $display("FAIL clr_ovfl: got %0d exp 0", ovfl_cnt); errors++; end
    checks++; if (level !== LW'(2)) begin $display("FAIL clr_level: got %0d exp 2", level); errors++; end
    // 30 beats into 6 free slots: 24 drops saturate at 15.
    for (int i = 0; i < 30; i++) begin
      beat(DATA_W'(300 + i), 3'b000);
      step();
    end
    idle();
    checks++; if (drop_cnt !== CNT_W'(15 * STATS)) begin $display("FAIL sat_drop: got %0d exp %0d", drop_cnt, 15 * STATS); errors++; end
    drain(8);
    checks++; if (empty !== 1'b1) begin $display("FAIL sat_drain_empty: got %b exp 1", empty); errors++; end
  endtask

  initial begin
    rst = 1'b1;
    clr_stat = 1'b0;
    rd_ready = 1'b0;
    idle();
    repeat (2) step();
    rst = 1'b0;
    step();
    test_reset();
    test_in_order();
    test_overflow();
    test_full_push_pop();
    test_flags();
    test_saturation_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
